// File: rtl/muldiv_unit_pkg.sv
// Shared encodings for the iterative multiply/divide engine: op codes, FSM states
// and the constant Lo value produced by a divide by zero.
package muldiv_unit_pkg;

   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PREP,
      ST_ITER,
      ST_FIX,
      ST_WRITE
   } state_t;

   localparam logic [31:0] DIVZ_LO = 32'hFFFF_FFFF;

   function automatic logic op_is_signed(input logic [1:0] op);
      return (op == OP_MULT) || (op == OP_DIV);
   endfunction

   function automatic logic op_is_div(input logic [1:0] op);
      return (op == OP_DIV) || (op == OP_DIVU);
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational radix-2 iteration: shift-add multiply or restoring divide
// on a {hi, lo} accumulator, with the lo half holding multiplier / dividend bits.
module muldiv_step #(
   parameter int WIDTH = 32
) (
   input  logic                   mode_div_i,
   input  logic [2*WIDTH-1:0]     acc_i,
   input  logic [WIDTH-1:0]       opnd_i,
   output logic [2*WIDTH-1:0]     acc_o
);

   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH-1:0] diff;
   logic             ge;

   always_comb begin
      sum    = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + {1'b0, opnd_i};
      rem_sh = {acc_i[2*WIDTH-1:WIDTH], acc_i[WIDTH-1]};
      // Only the low WIDTH bits of the difference survive whenever the subtract is taken.
      diff   = rem_sh[WIDTH-1:0] - opnd_i;
      ge     = (rem_sh >= {1'b0, opnd_i});
      acc_o  = acc_i;
      if (mode_div_i) begin
         if (ge) acc_o = {diff, acc_i[WIDTH-2:0], 1'b1};
         else    acc_o = {rem_sh[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
      end else begin
         if (acc_i[0]) acc_o = {sum, acc_i[WIDTH-1:1]};
         else          acc_o = {1'b0, acc_i[2*WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU engine writing {Hi, Lo}; requests a pipeline
// stall while busy if the EX instruction touches HiLo or tries to launch again.
module muldiv_unit
   import muldiv_unit_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic                 Clock,
   input  logic                 Reset,
   input  logic                 Start,
   input  logic [1:0]           Op,
   input  logic [WIDTH-1:0]     A,
   input  logic [WIDTH-1:0]     B,
   input  logic                 HiLoAccess,
   output logic                 Busy,
   output logic                 Stall,
   output logic                 HiLoEn,
   output logic [2*WIDTH-1:0]   HiLoWrite
);

   state_t               state_q;
   logic [CNT_W-1:0]     cnt_q;
   logic [1:0]           op_q;
   logic [WIDTH-1:0]     a_q, b_q, opnd_q;
   logic [2*WIDTH-1:0]   acc_q, hilo_q;
   logic                 sgn_quo_q, sgn_rem_q;
   logic                 busy_q, hiloen_q;

   logic                 signed_op;
   logic [WIDTH-1:0]     mag_a, mag_b, quo, rem;
   logic [2*WIDTH-1:0]   step_acc, result_d;

   muldiv_step #(.WIDTH(WIDTH)) u_step (
      .mode_div_i (op_is_div(op_q)),
      .acc_i      (acc_q),
      .opnd_i     (opnd_q),
      .acc_o      (step_acc)
   );

   always_comb begin
      signed_op = op_is_signed(op_q);
      mag_a     = (signed_op && a_q[WIDTH-1]) ? -a_q : a_q;
      mag_b     = (signed_op && b_q[WIDTH-1]) ? -b_q : b_q;
      quo       = acc_q[WIDTH-1:0];
      rem       = acc_q[2*WIDTH-1:WIDTH];
      result_d  = acc_q;
      if (!op_is_div(op_q)) begin
         if (signed_op && sgn_quo_q) result_d = -acc_q;
      end else if (opnd_q == '0) begin
         // Divide by zero returns the raw dividend in Hi regardless of signedness.
         result_d = {a_q, DIVZ_LO};
      end else begin
         if (signed_op && sgn_quo_q) quo = -acc_q[WIDTH-1:0];
         if (signed_op && sgn_rem_q) rem = -acc_q[2*WIDTH-1:WIDTH];
         result_d = {rem, quo};
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
         hiloen_q <= 1'b0;
         hilo_q   <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               hiloen_q <= 1'b0;
               if (Start) begin
                  op_q    <= Op;
                  a_q     <= A;
                  b_q     <= B;
                  busy_q  <= 1'b1;
                  state_q <= ST_PREP;
               end
            end
            ST_PREP: begin
               opnd_q    <= mag_b;
               acc_q     <= {{WIDTH{1'b0}}, mag_a};
               sgn_quo_q <= signed_op & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
               sgn_rem_q <= signed_op & a_q[WIDTH-1];
               cnt_q     <= CNT_W'(WIDTH - 1);
               state_q   <= ST_ITER;
            end
            ST_ITER: begin
               acc_q <= step_acc;
               if (cnt_q == '0) state_q <= ST_FIX;
               else             cnt_q   <= cnt_q - 1'b1;
            end
            ST_FIX: begin
               hilo_q   <= result_d;
               hiloen_q <= 1'b1;
               state_q  <= ST_WRITE;
            end
            ST_WRITE: begin
               hiloen_q <= 1'b0;
               busy_q   <= 1'b0;
               state_q  <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign Busy      = busy_q;
   assign Stall     = busy_q & (HiLoAccess | Start);
   assign HiLoEn    = hiloen_q;
   assign HiLoWrite = hilo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: results, latency, stall behaviour and reset abort.
module tb_muldiv_unit;

   logic        Clock = 1'b0;
   logic        Reset, Start, HiLoAccess;
   logic [1:0]  Op;
   logic [31:0] A, B;
   logic        Busy, Stall, HiLoEn;
   logic [63:0] HiLoWrite;

   int checks   = 0;
   int failures = 0;

   muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
      .Clock      (Clock),
      .Reset      (Reset),
      .Start      (Start),
      .Op         (Op),
      .A          (A),
      .B          (B),
      .HiLoAccess (HiLoAccess),
      .Busy       (Busy),
      .Stall      (Stall),
      .HiLoEn     (HiLoEn),
      .HiLoWrite  (HiLoWrite)
   );

   always #5 Clock = ~Clock;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Launch one op, then scramble the operands and watch 40 cycles.
   task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input string tag, input logic [63:0] exp);
      int          en_cyc, pulses, busy_bad;
      logic [63:0] got;
      @(negedge Clock);
      Start = 1'b1; Op = op; A = a; B = b;
      @(negedge Clock);
      Start = 1'b0; Op = ~op; A = ~a; B = b + 32'd3;
      en_cyc = 0; pulses = 0; busy_bad = 0; got = '0;
      for (int cyc = 1; cyc <= 40; cyc++) begin
         if (HiLoEn) begin
            pulses++;
            en_cyc = cyc;
            got    = HiLoWrite;
         end
         if (Busy !== (cyc <= 35)) busy_bad++;
         @(negedge Clock);
      end
      chk({tag, "_result"}, got, exp);
      chk({tag, "_pulses"}, 64'(pulses), 64'd1);
      chk({tag, "_latency"}, 64'(en_cyc), 64'd35);
      chk({tag, "_busy_window"}, 64'(busy_bad), 64'd0);
      chk({tag, "_hold"}, HiLoWrite, exp);
   endtask

   initial begin
      int          pulses;
      logic [63:0] got;
      Reset = 1'b1; Start = 1'b0; HiLoAccess = 1'b0; Op = 2'b00; A = '0; B = '0;
      repeat (3) @(negedge Clock);
      chk("rst_busy", 64'(Busy), 64'd0);
      chk("rst_stall", 64'(Stall), 64'd0);
      chk("rst_hiloen", 64'(HiLoEn), 64'd0);
      chk("rst_hilowrite", HiLoWrite, 64'd0);
      Reset = 1'b0;

      run_op(2'b00, 32'hFFFF_FFFD, 32'd7,          "mult_neg3x7",   64'hFFFF_FFFF_FFFF_FFEB);
      run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  "multu_max",     64'hFFFF_FFFE_0000_0001);
      run_op(2'b10, 32'hFFFF_FFF9, 32'd2,          "div_neg7by2",   64'hFFFF_FFFF_FFFF_FFFD);
      run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF,  "div_minint",    64'h0000_0000_8000_0000);
      run_op(2'b11, 32'd100,       32'd0,          "divu_by0",      64'h0000_0064_FFFF_FFFF);
      run_op(2'b10, 32'hFFFF_FFF9, 32'd0,          "div_neg_by0",   64'hFFFF_FFF9_FFFF_FFFF);

      // Stall: repeated Start at cycle 10, HiLo access at cycles 20 and 35 (WRITE).
      @(negedge Clock);
      Start = 1'b1; Op = 2'b01; A = 32'd5; B = 32'd6;
      @(negedge Clock);
      Start = 1'b0;
      pulses = 0; got = '0;
      for (int cyc = 1; cyc <= 40; cyc++) begin
         Start      = (cyc == 10);
         HiLoAccess = (cyc == 20) || (cyc == 35) || (cyc == 37);
         if (cyc == 10) begin Op = 2'b00; A = 32'd9; B = 32'd9; end
         #1;
         if (cyc == 5)  chk("stall_idle_busy", 64'(Stall), 64'd0);
         if (cyc == 10) chk("stall_restart", 64'(Stall), 64'd1);
         if (cyc == 20) chk("stall_hiloaccess", 64'(Stall), 64'd1);
         if (cyc == 35) chk("stall_write_cycle", 64'(Stall), 64'd1);
         if (cyc == 37) chk("stall_after_done", 64'(Stall), 64'd0);
         if (HiLoEn) begin pulses++; got = HiLoWrite; end
         @(negedge Clock);
      end
      Start = 1'b0; HiLoAccess = 1'b0;
      chk("stall_result", got, 64'h0000_0000_0000_001E);
      chk("stall_pulses", 64'(pulses), 64'd1);
      chk("stall_no_restart_busy", 64'(Busy), 64'd0);

      // Reset at cycle 15 of a DIV aborts with no write and clears HiLoWrite.
      @(negedge Clock);
      Start = 1'b1; Op = 2'b10; A = 32'd100; B = 32'd7;
      @(negedge Clock);
      Start = 1'b0;
      repeat (14) @(negedge Clock);
      Reset = 1'b1;
      @(negedge Clock);
      Reset = 1'b0;
      chk("abort_busy", 64'(Busy), 64'd0);
      pulses = 0;
      for (int cyc = 0; cyc < 40; cyc++) begin
         if (HiLoEn) pulses++;
         @(negedge Clock);
      end
      chk("abort_pulses", 64'(pulses), 64'd0);
      chk("abort_hilowrite", HiLoWrite, 64'd0);

      // Reset and Start together: reset wins.
      Reset = 1'b1; Start = 1'b1; Op = 2'b01; A = 32'd3; B = 32'd3;
      @(negedge Clock);
      Reset = 1'b0; Start = 1'b0;
      @(negedge Clock);
      chk("reset_beats_start", 64'(Busy), 64'd0);

      run_op(2'b11, 32'd100, 32'd7, "divu_after_reset", 64'h0000_0002_0000_000E);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
